stage_operator_mixer: RTL and testbench

//  Final pipeline stage, directly downstream of the envelope attenuator. Stores every

---
 rtl/stage_operator_mixer_pkg.sv | 18 +
 rtl/stage_operator_mixer_buffer.sv | 35 +++
 rtl/stage_operator_mixer.sv | 135 +++++++++++++
 tb/tb_stage_operator_mixer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_operator_mixer_pkg.sv
// Shared types for the operator output stage: operator IDs, the algorithm word
// fields this stage consumes, and the audio sample type.
package stage_operator_mixer_pkg;

  localparam int NUM_VOICE_OPERATORS     = 64;
  localparam int VOICE_OPERATOR_ID_WIDTH = $clog2(NUM_VOICE_OPERATORS);

  typedef logic [VOICE_OPERATOR_ID_WIDTH-1:0] VoiceOperatorID_t;

  typedef struct packed {
    logic IsCarrier;
  } AlgorithmWord_t;

  typedef logic signed [15:0] Sample_t;

  localparam VoiceOperatorID_t LAST_VOICE_OPERATOR = VoiceOperatorID_t'(NUM_VOICE_OPERATORS - 1);

endpackage

// File: rtl/stage_operator_mixer_buffer.sv
// Modulation buffer: one 16-bit entry per voice operator, one write and one
// registered read per clock. A read that collides with a write sees the old entry.
module operator_output_buffer
  import stage_operator_mixer_pkg::*;
(
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_WriteEnable,
  input  VoiceOperatorID_t i_WriteAddr,
  input  Sample_t          i_WriteData,
  input  VoiceOperatorID_t i_ReadAddr,
  output Sample_t          o_ReadData
);

  Sample_t mem_q [NUM_VOICE_OPERATORS];
  Sample_t read_data_q;

  // Array kept free of reset so it maps onto a single block RAM.
  always_ff @(posedge i_Clock) begin
    if (i_WriteEnable) begin
      mem_q[i_WriteAddr] <= i_WriteData;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= mem_q[i_ReadAddr];
    end
  end

  assign o_ReadData = read_data_q;

endmodule

// File: rtl/stage_operator_mixer.sv
// Final stage: buffers every operator output for FM, sums carriers over one
// voice-operator frame and hands the scaled, saturated sum downstream.
module stage_operator_mixer
  import stage_operator_mixer_pkg::*;
#(
  parameter int ACC_WIDTH    = 24,
  parameter int OUTPUT_SHIFT = 3
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  VoiceOperatorID_t i_VoiceOperator,
  input  AlgorithmWord_t   i_AlgorithmWord,
  input  Sample_t          i_Waveform,
  input  VoiceOperatorID_t i_ModReadAddr,
  output Sample_t          o_ModReadData,
  output Sample_t          o_Sample,
  output logic             o_SampleValid,
  input  logic             i_SampleReady,
  output logic             o_SampleDropped,
  input  logic             i_ClearDropped
);

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  Sample_t wave_q;
  logic    carrier_q;
  logic    last_q;
  logic    stage1_valid_q;

  acc_t    acc_q, acc_d;
  acc_t    frame_sum_q, frame_sum_d;
  acc_t    contribution;
  logic    frame_done_q, frame_done_d;

  acc_t    shifted_sum;
  Sample_t mixed_sample;
  logic    drop;
  Sample_t sample_q, sample_d;
  logic    sample_valid_q, sample_valid_d;
  logic    dropped_q, dropped_d;

  function automatic Sample_t saturate(input acc_t value);
    if (value > acc_t'(32767)) begin
      return 16'sh7FFF;
    end else if (value < acc_t'(-32768)) begin
      return 16'sh8000;
    end
    return Sample_t'(value);
  endfunction

  operator_output_buffer u_buffer (
    .i_Clock       (i_Clock),
    .i_Reset       (i_Reset),
    .i_WriteEnable (1'b1),
    .i_WriteAddr   (i_VoiceOperator),
    .i_WriteData   (i_Waveform),
    .i_ReadAddr    (i_ModReadAddr),
    .o_ReadData    (o_ModReadData)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wave_q         <= '0;
      carrier_q      <= 1'b0;
      last_q         <= 1'b0;
      stage1_valid_q <= 1'b0;
    end else begin
      wave_q         <= i_Waveform;
      carrier_q      <= i_AlgorithmWord.IsCarrier;
      last_q         <= (i_VoiceOperator == LAST_VOICE_OPERATOR);
      stage1_valid_q <= 1'b1;
    end
  end

  always_comb begin
    contribution = carrier_q ? acc_t'(wave_q) : '0;
    acc_d        = acc_q;
    frame_sum_d  = frame_sum_q;
    frame_done_d = 1'b0;
    if (stage1_valid_q) begin
      if (last_q) begin
        frame_sum_d  = acc_q + contribution;
        acc_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        acc_d = acc_q + contribution;
      end
    end
  end

  always_comb begin
    shifted_sum    = frame_sum_q >>> OUTPUT_SHIFT;
    mixed_sample   = saturate(shifted_sum);
    drop           = frame_done_q && sample_valid_q && !i_SampleReady;
    sample_d       = sample_q;
    sample_valid_d = sample_valid_q;
    dropped_d      = dropped_q;
    if (sample_valid_q && i_SampleReady) begin
      sample_valid_d = 1'b0;
    end
    if (frame_done_q && !drop) begin
      sample_d       = mixed_sample;
      sample_valid_d = 1'b1;
    end
    // A drop in the same cycle as a clear request keeps the flag set.
    if (drop) begin
      dropped_d = 1'b1;
    end else if (i_ClearDropped) begin
      dropped_d = 1'b0;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      acc_q          <= '0;
      frame_sum_q    <= '0;
      frame_done_q   <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      dropped_q      <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      frame_sum_q    <= frame_sum_d;
      frame_done_q   <= frame_done_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      dropped_q      <= dropped_d;
    end
  end

  assign o_Sample        = sample_q;
  assign o_SampleValid   = sample_valid_q;
  assign o_SampleDropped = dropped_q;

endmodule

// File: tb/tb_stage_operator_mixer.sv
// Directed bench for stage_operator_mixer: frame-level model plus literal checks
// for the mixing, saturation, buffer collision, drop and mid-frame reset cases.
module tb_stage_operator_mixer;
  import stage_operator_mixer_pkg::*;

  localparam int N = NUM_VOICE_OPERATORS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  VoiceOperatorID_t vo;
  AlgorithmWord_t   aw;
  Sample_t          wave;
  VoiceOperatorID_t raddr;
  Sample_t          rdata;
  Sample_t          sample;
  logic             svalid;
  logic             sready;
  logic             sdrop;
  logic             clr;

  stage_operator_mixer #(.ACC_WIDTH(24), .OUTPUT_SHIFT(3)) dut (
    .i_Clock         (clk),
    .i_Reset         (rst),
    .i_VoiceOperator (vo),
    .i_AlgorithmWord (aw),
    .i_Waveform      (wave),
    .i_ModReadAddr   (raddr),
    .o_ModReadData   (rdata),
    .o_Sample        (sample),
    .o_SampleValid   (svalid),
    .i_SampleReady   (sready),
    .o_SampleDropped (sdrop),
    .i_ClearDropped  (clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wv [N];
  bit cr [N];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Frame-level model: one pending sample per finished frame, delivered two
  // edges after its last operator is captured.
  int m_edge = 0;
  int m_fsum = 0;
  int pend_edge [$];
  int pend_val  [$];
  int exp_sample = 0;
  bit exp_valid = 0;
  bit exp_drop = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fsum = 0;
      pend_edge.delete();
      pend_val.delete();
      exp_sample = 0;
      exp_valid = 0;
      exp_drop = 0;
    end else begin
      bit arrive;
      bit blocked;
      m_edge++;
      arrive  = (pend_edge.size() > 0) && (pend_edge[0] == m_edge);
      blocked = arrive && exp_valid && !sready;
      if (exp_valid && sready) exp_valid = 0;
      if (arrive) begin
        if (!blocked) begin
          exp_sample = pend_val[0];
          exp_valid  = 1;
        end
        void'(pend_edge.pop_front());
        void'(pend_val.pop_front());
      end
      if (blocked) exp_drop = 1;
      else if (clr) exp_drop = 0;
      if (aw.IsCarrier) m_fsum += int'(wave);
      if (int'(vo) == N - 1) begin
        pend_edge.push_back(m_edge + 2);
        pend_val.push_back(sat16(m_fsum >>> 3));
        m_fsum = 0;
      end
    end
  end

  int mem [N];
  bit mem_known [N];
  int exp_rd = 0;
  bit exp_rd_known = 1;

  always @(posedge clk) begin
    if (rst) begin
      exp_rd = 0;
      exp_rd_known = 1;
    end else begin
      exp_rd = mem[raddr];
      exp_rd_known = mem_known[raddr];
    end
    mem[vo] = int'(wave);
    mem_known[vo] = 1;
  end

  always @(posedge clk) begin
    #1;
    chk("sample_valid", int'(svalid), int'(exp_valid));
    if (exp_valid) chk("sample", int'(sample), exp_sample);
    chk("dropped", int'(sdrop), int'(exp_drop));
    if (exp_rd_known) chk("mod_read", int'(rdata), exp_rd);
  end

  int cyc = 0;
  int acc_val [$];
  int acc_cyc [$];

  always @(posedge clk) begin
    if (!rst && svalid && sready) begin
      acc_val.push_back(int'(sample));
      acc_cyc.push_back(cyc);
      $display("sample accepted: %0d at cycle %0d", int'(sample), cyc);
    end
    cyc++;
  end

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      wv[i] = 0;
      cr[i] = 0;
    end
  endtask

  task automatic drive(input int id);
    vo             = VoiceOperatorID_t'(id);
    wave           = Sample_t'(wv[id]);
    aw.IsCarrier   = cr[id];
  endtask

  task automatic run_frame(input int first, output int last_drive_cyc);
    for (int id = first; id < N; id++) begin
      @(negedge clk);
      drive(id);
    end
    last_drive_cyc = cyc;
  endtask

  int last1;
  int dummy;
  int exp_list [8] = '{125, 32767, -32768, 0, 100, 154, 22, 0};

  initial begin
    vo = '0; aw = '0; wave = '0; raddr = '0; sready = 1'b1; clr = 1'b0;
    clear_frame();

    repeat (3) @(negedge clk);
    chk("reset_sample", int'(sample), 0);
    chk("reset_valid", int'(svalid), 0);
    chk("reset_dropped", int'(sdrop), 0);
    chk("reset_mod_read", int'(rdata), 0);

    // F1: single carrier at ID 5
    wv[5] = 1000; cr[5] = 1;
    rst = 1'b0;
    drive(0);
    run_frame(1, last1);

    // F2/F3: full-scale carriers saturate both ways
    for (int i = 0; i < N; i++) begin wv[i] = 32767; cr[i] = 1; end
    run_frame(0, dummy);
    for (int i = 0; i < N; i++) wv[i] = -32768;
    run_frame(0, dummy);

    // F4: modulator only
    clear_frame();
    wv[7] = 20000;
    run_frame(0, dummy);

    // F5: read back the modulator value while mixing a small carrier
    clear_frame();
    wv[0] = 800; cr[0] = 1;
    for (int id = 0; id < N; id++) begin
      @(negedge clk);
      if (id == 0) raddr = VoiceOperatorID_t'(7);
      if (id == 3) chk("mod_read_id7", int'(rdata), 20000);
      drive(id);
    end

    // F6: downstream stalls
    clear_frame();
    wv[0] = 1600; cr[0] = 1; wv[10] = 555;
    for (int id = 0; id < N; id++) begin
      @(negedge clk);
      if (id == 0) sready = 1'b0;
      drive(id);
    end

    // F7: held sample, drop flag, clear, and read/write collision on ID 10
    clear_frame();
    wv[10] = 1234; cr[10] = 1;
    raddr = VoiceOperatorID_t'(10);
    for (int id = 0; id < N; id++) begin
      @(negedge clk);
      if (id == 11) chk("collision_old", int'(rdata), 555);
      if (id == 12) chk("collision_new", int'(rdata), 1234);
      if (id == 20) begin
        chk("held_sample", int'(sample), 100);
        chk("held_valid", int'(svalid), 1);
        chk("drop_set", int'(sdrop), 1);
        sready = 1'b1;
      end
      if (id == 25) clr = 1'b1;
      if (id == 26) begin
        clr = 1'b0;
        chk("drop_cleared", int'(sdrop), 0);
      end
      drive(id);
    end

    // F8: reset asserted at ID 40, released at ID 42
    for (int i = 0; i < N; i++) begin wv[i] = 8; cr[i] = 1; end
    for (int id = 0; id < N; id++) begin
      @(negedge clk);
      drive(id);
      if (id == 40) begin
        rst = 1'b1;
        #1;
        chk("midreset_sample", int'(sample), 0);
        chk("midreset_valid", int'(svalid), 0);
        chk("midreset_dropped", int'(sdrop), 0);
        chk("midreset_mod_read", int'(rdata), 0);
      end
      if (id == 42) rst = 1'b0;
    end

    clear_frame();
    run_frame(0, dummy);
    for (int id = 0; id < 10; id++) begin
      @(negedge clk);
      drive(id);
    end
    @(negedge clk);

    chk("accepted_count", acc_val.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < acc_val.size()) chk($sformatf("accepted_%0d", i), acc_val[i], exp_list[i]);
      else chk($sformatf("accepted_%0d_missing", i), 1, 0);
    end
    if (acc_cyc.size() > 0) chk("first_latency", acc_cyc[0] - last1, 3);
    else chk("first_latency_missing", 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
